ica_convergence_check: RTL and testbench



---
 rtl/ica_convergence_check.sv | 140 ++++++++++++++
 tb/tb_ica_convergence_check.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ica_convergence_check.sv
// Convergence monitor and iteration controller for the FastICA weight update loop.
// Serially computes w_new.w_old and stops when |dot| is within TOL of 1.0 or after MAX_ITER passes.
module ica_convergence_check #(
   parameter int N          = 7,
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_WIDTH = 10,
   parameter int TOL        = 4,
   parameter int MAX_ITER   = 32,
   parameter int ITER_WIDTH = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [N*DATA_WIDTH-1:0] w_init,
   input  logic                    upd_valid,
   input  logic [N*DATA_WIDTH-1:0] upd_w,
   output logic                    upd_en,
   output logic                    upd_clr,
   output logic [N*DATA_WIDTH-1:0] w_old,
   output logic                    busy,
   output logic                    done,
   output logic                    converged,
   output logic                    timed_out,
   output logic [ITER_WIDTH-1:0]   iter_count
);

   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int PROD_W = 2 * DATA_WIDTH;
   localparam int ACC_W = PROD_W + $clog2(N);
   localparam int DOT_W = ACC_W - FRAC_WIDTH;
   localparam logic [DOT_W-1:0] THRESH = DOT_W'((1 << FRAC_WIDTH) - TOL);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_MAC,
      S_DECIDE,
      S_DONE
   } state_t;

   state_t                    state;
   logic [N*DATA_WIDTH-1:0]   w_new;
   logic [IDX_W-1:0]          idx;
   logic signed [ACC_W-1:0]   acc;
   logic signed [DATA_WIDTH-1:0] a_el;
   logic signed [DATA_WIDTH-1:0] b_el;
   logic signed [PROD_W-1:0]  prod;
   logic                      hit;

   // Sign ambiguity of ICA: w and -w are the same component, so compare |dot|.
   function automatic logic dot_hit(input logic signed [ACC_W-1:0] a);
      logic signed [DOT_W-1:0] dot;
      logic [DOT_W-1:0]        mag;
      dot = DOT_W'(a >>> FRAC_WIDTH);
      mag = dot[DOT_W-1] ? $unsigned(-dot) : $unsigned(dot);
      return mag >= THRESH;
   endfunction

   // Multiply stage: one element pair per MAC cycle, full precision
   always_comb begin
      a_el = $signed(w_new[idx*DATA_WIDTH +: DATA_WIDTH]);
      b_el = $signed(w_old[idx*DATA_WIDTH +: DATA_WIDTH]);
      prod = a_el * b_el;
      hit  = dot_hit(acc);
   end

   // Control, accumulate and decision stage
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         w_old      <= '0;
         w_new      <= '0;
         acc        <= '0;
         idx        <= '0;
         iter_count <= '0;
         upd_en     <= 1'b0;
         upd_clr    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         converged  <= 1'b0;
         timed_out  <= 1'b0;
      end else begin
         upd_clr <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  w_old      <= w_init;
                  iter_count <= '0;
                  converged  <= 1'b0;
                  timed_out  <= 1'b0;
                  done       <= 1'b0;
                  busy       <= 1'b1;
                  upd_en     <= 1'b1;
                  state      <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (upd_valid) begin
                  w_new  <= upd_w;
                  acc    <= '0;
                  idx    <= '0;
                  upd_en <= 1'b0;
                  state  <= S_MAC;
               end
            end
            S_MAC: begin
               acc <= acc + ACC_W'(prod);
               if (idx == IDX_W'(N - 1)) begin
                  idx     <= '0;
                  upd_clr <= 1'b1;
                  state   <= S_DECIDE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_DECIDE: begin
               w_old      <= w_new;
               iter_count <= iter_count + 1'b1;
               // A hit on the final permitted iteration still reports convergence.
               if (hit) begin
                  converged <= 1'b1;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state     <= S_DONE;
               end else if (iter_count == ITER_WIDTH'(MAX_ITER - 1)) begin
                  timed_out <= 1'b1;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state     <= S_DONE;
               end else begin
                  upd_en <= 1'b1;
                  state  <= S_WAIT;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ica_convergence_check.sv
// Bench for ica_convergence_check: acts as the update stage and compares every iteration
// against a dot-product reference model computed with plain integer arithmetic.
module tb_ica_convergence_check;

   localparam int N        = 7;
   localparam int DW       = 16;
   localparam int MAX_ITER = 32;
   localparam int THRESH   = 1024 - 4;

   typedef logic [N*DW-1:0] vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   vec_t       w_init;
   logic       upd_valid;
   vec_t       upd_w;
   logic       upd_en;
   logic       upd_clr;
   vec_t       w_old;
   logic       busy;
   logic       done;
   logic       converged;
   logic       timed_out;
   logic [5:0] iter_count;

   int n_checks = 0;
   int n_errors = 0;
   int clr_cnt  = 0;

   ica_convergence_check dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .w_init     (w_init),
      .upd_valid  (upd_valid),
      .upd_w      (upd_w),
      .upd_en     (upd_en),
      .upd_clr    (upd_clr),
      .w_old      (w_old),
      .busy       (busy),
      .done       (done),
      .converged  (converged),
      .timed_out  (timed_out),
      .iter_count (iter_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (upd_clr) clr_cnt++;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic vec_t unit(input int k, input int val);
      vec_t v;
      v = '0;
      v[k*DW +: DW] = 16'(val);
      return v;
   endfunction

   function automatic vec_t noise_vec();
      return vec_t'({$urandom(), $urandom(), $urandom(), $urandom()});
   endfunction

   // Near-unit vector along e0 or e1 with small noise, so |dot| lands around the threshold.
   function automatic vec_t rand_vec();
      vec_t v;
      int   val;
      int   k;
      for (int i = 0; i < N; i++) begin
         val = int'($urandom_range(16, 0)) - 8;
         v[i*DW +: DW] = 16'(val);
      end
      k   = int'($urandom_range(1, 0));
      val = int'($urandom_range(1030, 1010));
      if ($urandom_range(1, 0) == 1) val = -val;
      v[k*DW +: DW] = 16'(val);
      return v;
   endfunction

   function automatic bit model_hit(input vec_t a, input vec_t b);
      longint s;
      s = 0;
      for (int i = 0; i < N; i++)
         s += longint'($signed(a[i*DW +: DW])) * longint'($signed(b[i*DW +: DW]));
      s = s >>> 10;
      if (s < 0) s = -s;
      return s >= THRESH;
   endfunction

   task automatic check_reset(input string tag);
      check({tag, "_upd_en"}, upd_en, 0);
      check({tag, "_upd_clr"}, upd_clr, 0);
      check({tag, "_w_old"}, w_old, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_converged"}, converged, 0);
      check({tag, "_timed_out"}, timed_out, 0);
      check({tag, "_iter_count"}, iter_count, 0);
   endtask

   // mode 0: update returns `fixed`; mode 1: alternates e1/e0; mode 2: random near-unit vectors.
   task automatic do_run(input vec_t init, input int mode, input vec_t fixed, input bit disturb);
      vec_t m_old;
      vec_t resp;
      int   m_iter;
      bit   m_conv;
      bit   m_to;
      bit   h;
      int   lat;
      int   tmo;
      int   base;
      base   = clr_cnt;
      m_old  = init;
      m_iter = 0;
      m_conv = 0;
      m_to   = 0;
      @(negedge clk);
      w_init = init;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      w_init = noise_vec();
      while (!m_conv && !m_to) begin
         tmo = 0;
         while (!upd_en && tmo < 20) begin
            @(negedge clk);
            tmo++;
         end
         if (!upd_en) begin
            check("en_wait", 0, 1);
            return;
         end
         case (mode)
            0:       resp = fixed;
            1:       resp = (m_iter % 2 == 0) ? unit(1, 1024) : unit(0, 1024);
            default: resp = rand_vec();
         endcase
         upd_w     = resp;
         upd_valid = 1'b1;
         @(negedge clk);
         upd_valid = 1'b0;
         upd_w     = noise_vec();
         h = model_hit(m_old, resp);
         m_old = resp;
         m_iter++;
         if (h) m_conv = 1;
         else if (m_iter == MAX_ITER) m_to = 1;
         // Done/upd_en appear 8 edges after the edge that sampled upd_valid (9th cycle overall).
         lat = 0;
         do begin
            @(negedge clk);
            lat++;
            start     = disturb && lat == 3;
            upd_valid = disturb && lat == 7;
         end while (!done && !upd_en && lat < 20);
         start     = 1'b0;
         upd_valid = 1'b0;
         check("latency", lat, 8);
         check("done", done, m_conv || m_to);
         check("converged", converged, m_conv);
         check("timed_out", timed_out, m_to);
         check("iter_count", iter_count, m_iter);
         check("w_old", w_old, m_old);
         check("busy", busy, !(m_conv || m_to));
         check("upd_en", upd_en, !(m_conv || m_to));
         check("clr_pulses", clr_cnt - base, m_iter);
         if (lat >= 20) return;
      end
   endtask

   task automatic reset_mid_mac();
      int tmo;
      @(negedge clk);
      w_init = unit(0, 1024);
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tmo = 0;
      while (!upd_en && tmo < 20) begin
         @(negedge clk);
         tmo++;
      end
      check("mid_mac_en_wait", upd_en, 1);
      upd_w     = unit(0, 1024);
      upd_valid = 1'b1;
      @(negedge clk);
      upd_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset("mid_mac");
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      upd_valid = 1'b0;
      w_init    = '0;
      upd_w     = '0;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;

      do_run(unit(0, 1024), 0, unit(0, 1024), 1'b0);
      do_run(unit(0, 1024), 0, unit(0, -1024), 1'b1);
      do_run(unit(0, 1024), 0, unit(0, 'h3FC), 1'b0);
      do_run(unit(0, 1024), 0, unit(0, 'h3FB), 1'b0);
      do_run(unit(0, 1024), 1, '0, 1'b0);
      reset_mid_mac();
      do_run(unit(0, 1024), 0, unit(0, 1024), 1'b0);
      for (int r = 0; r < 8; r++)
         do_run(rand_vec(), 2, '0, $urandom_range(1, 0) == 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
